// File: rtl/posit_pkg.sv
// posit_pkg: shared constants and stage-1 record for posit32 (es=3) to fp32 conversion
package posit_pkg;
  localparam int FS = 26;
  localparam int RS = 6;
  localparam int ES = 3;
  localparam int FP32_BIAS = 127;
  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;
  localparam logic [31:0] FP32_MAXF = 32'h7F7F_FFFF;
  typedef struct packed {
    logic        sign;
    logic        nar;
    logic        zero;
    logic [9:0]  scale;
    logic [22:0] mant;
    logic [2:0]  grs;
  } s1_t;
endpackage

// File: rtl/fp32_round_pack.sv
// fp32_round_pack: round-to-nearest-even on mantissa+GRS, pack to binary32, saturate at max finite
module fp32_round_pack
  import posit_pkg::*;
(
  input  logic              sign_i,
  input  logic signed [9:0] exp_i,
  input  logic [22:0]       mant_i,
  input  logic [2:0]        grs_i,
  output logic [31:0]       fp32_o,
  output logic              ovf_o
);
  logic              rnd_up;
  logic              carry;
  logic [22:0]       mant_r;
  logic signed [9:0] exp_r;
  always_comb begin
    rnd_up = grs_i[2] & (grs_i[1] | grs_i[0] | mant_i[0]);
    {carry, mant_r} = {1'b0, mant_i} + 24'(rnd_up);
    exp_r = exp_i + 10'(carry);
    ovf_o = exp_r >= 10'sd255;
    fp32_o = ovf_o ? {sign_i, FP32_MAXF[30:0]} : {sign_i, exp_r[7:0], mant_r};
  end
endmodule

// File: rtl/posit32_to_fp32.sv
// posit32_to_fp32: 2-stage pipeline converting decoded posit32 fields to IEEE-754 binary32.
// Define POSIT_FP32_SUBNORM_EN to emit denormals instead of flushing E <= 0 to signed zero.
module posit32_to_fp32 #(
  parameter int FS = posit_pkg::FS,
  parameter int RS = posit_pkg::RS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          sign,
  input  logic [RS-1:0] regi,
  input  logic [2:0]    expo,
  input  logic [FS-1:0] frac,
  input  logic          allzero,
  input  logic          inf,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   fp32,
  output logic          ovf,
  output logic          unf
);
  import posit_pkg::*;
  s1_t               s1_q, s1_d;
  logic              s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic [31:0]       fp32_q, fp32_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              s2_adv, ld2, sub;
  logic signed [9:0] e, rp_exp;
  logic [22:0]       rp_mant;
  logic [2:0]        rp_grs;
  logic [31:0]       rp_fp32, sub_fp32;
  logic              rp_ovf;
  assign s2_adv   = !s2_valid_q | out_ready;
  assign in_ready = !s1_valid_q | s2_adv;
  always_comb begin
    s1_valid_d = in_ready ? in_valid : s1_valid_q;
    s1_d = (in_ready && in_valid) ? s1_t'{
      sign:  sign,
      nar:   inf,
      zero:  allzero,
      scale: (10'($signed(regi)) <<< 3) + 10'(expo),
      mant:  frac[FS-1 -: 23],
      grs:   {frac[FS-24], frac[FS-25], |frac[FS-26:0]}
    } : s1_q;
  end
  assign e   = $signed(s1_q.scale) + 10'(FP32_BIAS);
  assign sub = e <= 10'sd0;
`ifdef POSIT_FP32_SUBNORM_EN
  logic [9:0]  sh;
  logic [4:0]  shv;
  logic [26:0] v;
  logic [25:0] sv;
  logic        lost;
  // {1,mant,grs} >> (1-E); everything shifted past bit 0 collapses into sticky
  always_comb begin
    sh = 10'd1 - e;
    shv = (sh > 10'd27) ? 5'd27 : sh[4:0];
    v = {1'b1, s1_q.mant, s1_q.grs};
    sv = 26'(v >> shv);
    lost = |(v & ~(27'h7FF_FFFF << shv));
    rp_exp = sub ? 10'sd0 : e;
    rp_mant = sub ? sv[25:3] : s1_q.mant;
    rp_grs = sub ? {sv[2:1], sv[0] | lost} : s1_q.grs;
  end
  assign sub_fp32 = rp_fp32;
`else
  assign rp_exp   = e;
  assign rp_mant  = s1_q.mant;
  assign rp_grs   = s1_q.grs;
  assign sub_fp32 = {s1_q.sign, 31'b0};
`endif
  fp32_round_pack u_pack (
    .sign_i (s1_q.sign),
    .exp_i  (rp_exp),
    .mant_i (rp_mant),
    .grs_i  (rp_grs),
    .fp32_o (rp_fp32),
    .ovf_o  (rp_ovf)
  );
  always_comb begin
    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    ld2 = s2_adv & s1_valid_q;
    fp32_d = !ld2 ? fp32_q : s1_q.nar ? FP32_QNAN : s1_q.zero ? 32'd0 : sub ? sub_fp32 : rp_fp32;
    ovf_d = ld2 ? (!s1_q.nar & !s1_q.zero & !sub & rp_ovf) : ovf_q;
    unf_d = ld2 ? (!s1_q.nar & !s1_q.zero & sub) : unf_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      fp32_q     <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
      s2_valid_q <= s2_valid_d;
      fp32_q     <= fp32_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end
  assign out_valid = s2_valid_q;
  assign fp32      = fp32_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;
endmodule

// File: doc/posit32_to_fp32.md
POSIT32_TO_FP32 -- requirements
Module: posit32_to_fp32

Interface
REQ-001 SHALL have parameter FS, default 26, fraction width of decoded posit (n=32, es=3).
REQ-002 SHALL have parameter RS, default 6, regime field width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  decoded posit fields present.
REQ-006 in_ready  output  1  block accepts fields this cycle.
REQ-007 sign  input  1  posit sign; fields describe magnitude.
REQ-008 regi  input  RS  signed two's-complement regime value k.
REQ-009 expo  input  3  unsigned exponent field.
REQ-010 frac  input  FS  fraction bits after hidden 1, MSB first.
REQ-011 allzero  input  1  posit is zero.
REQ-012 inf  input  1  posit is NaR.
REQ-013 out_valid  output  1  fp32 result present.
REQ-014 out_ready  input  1  consumer accepts result.
REQ-015 fp32  output  32  IEEE-754 binary32 result.
REQ-016 ovf  output  1  result saturated to max finite.
REQ-017 unf  output  1  result flushed to zero or denormalised.

Function
REQ-018 SHALL transfer input when in_valid&in_ready, output when out_valid&out_ready.
REQ-019 SHALL be 2-stage pipeline: S1 registers scale/flags/fraction, S2 registers rounded packed result; latency 2 cycles with no stall.
REQ-020 Stage advances when empty or next stage advances; in_ready = !s1_valid | s1_advance (combinational from out_ready).
REQ-021 Stalled stage SHALL hold data unchanged; out_valid, once high, SHALL not drop until taken.
REQ-022 Scale = 8*k + expo as 10-bit signed; biased exponent E = scale + 127.
REQ-023 Mantissa = frac[FS-1:3]; guard frac[2], round frac[1], sticky frac[0]; round-to-nearest-even.
REQ-024 Mantissa carry-out SHALL increment E and zero mantissa.
REQ-025 E >= 255 (before or after rounding): fp32 = {sign, 0x7F7FFFFF[30:0]}, ovf=1.
REQ-026 inf=1: fp32 = 0x7FC00000, ovf=unf=0, regardless of other fields.
REQ-027 allzero=1: fp32 = 0x00000000, flags 0; inf takes priority over allzero.
REQ-028 E <= 0 handled per Configuration; unf=1.
REQ-029 ovf/unf SHALL be registered alongside fp32 and valid only with out_valid.
REQ-030 Back-to-back inputs SHALL sustain one result per cycle when out_ready=1.

Reset
REQ-031 On rst: s1/s2 valid=0, out_valid=0, fp32=0, ovf=0, unf=0; in_ready=1 first cycle after reset.
REQ-032 Reset mid-operation SHALL discard all in-flight data; no result emitted for it.

Configuration
REQ-033 Macro POSIT_FP32_SUBNORM_EN.
REQ-034 Defined: E <= 0 produces denormal, {1,mantissa} right-shifted by 1-E with shifted-out bits into sticky, RNE; shift > 24 gives signed zero; rounding into E=1 yields normal.
REQ-035 Undefined: E <= 0 flushes to {sign, 31'b0}; no shifter synthesised.

Structure
REQ-036 Shared package posit_pkg: FS, RS, ES=3, FP32_BIAS=127, FP32_QNAN=0x7FC00000, FP32_MAXF=0x7F7FFFFF, stage-1 struct type.
REQ-037 One sub-module fp32_round_pack (mantissa+GRS, E, sign -> fp32, ovf), instantiated in S2.

Verification
REQ-038 k=0, expo=0, frac=0 -> fp32=0x3F800000, flags 0, out_valid 2 cycles after accept.
REQ-039 k=-1, expo=7, frac=0 -> 0x3F000000; inf=1 -> 0x7FC00000; allzero=1 -> 0x00000000.
REQ-040 k=0, expo=0, frac=0x000000C -> 0x3F800002 (tie, odd lsb up); frac=0x0000004 -> 0x3F800000 (tie, even).
REQ-041 k=16, expo=0, sign=1 -> 0xFF7FFFFF, ovf=1.
REQ-042 k=-16, expo=1, frac=0 -> 0x00000000 unf=1 without macro; 0x00400000 unf=1 with macro.
REQ-043 10 back-to-back inputs, out_ready toggled 1,0,0,1: all results in order, none lost or duplicated; rst asserted mid-stream -> out_valid=0 next cycle.
